// File: rtl/arbitro_pkg.sv
// Shared constants, FSM states and slot helper for the arbitro_mux8 arbiter.
package arbitro_pkg;

  localparam int N     = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    OCIOSO   = 1'b0,
    SERVINDO = 1'b1
  } estado_t;

  // LSB of slot idx inside the packed dados_in bus
  function automatic int unsigned slot_lsb(
    input logic [SEL_W-1:0] idx,
    input int unsigned      w
  );
    return int'(idx) * w;
  endfunction

endpackage

// File: rtl/arbitro_mux8_rr_seletor.sv
// Combinational winner picker: round-robin from ptr, or lowest index
// when FIXED_PRIORITY_EN is defined.
module rr_seletor
  import arbitro_pkg::*;
(
  input  logic [N-1:0]     eligible,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

`ifdef FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  logic [SEL_W-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
`ifdef FIXED_PRIORITY_EN
      idx = SEL_W'(k);
`else
      idx = ptr + SEL_W'(k);
`endif
      if (!any && eligible[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_mux8.sv
// 8-way arbiter/sequencer driving the mux select with a valid/ready output.
// Build option: FIXED_PRIORITY_EN selects lowest-index priority.
module arbitro_mux8
  import arbitro_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   dados_in,
  input  logic             pronto_in,
  output logic [SEL_W-1:0] endereco,
  output logic [W-1:0]     dados_out,
  output logic             valido_out,
  output logic [N-1:0]     ack,
  output logic             ocupado
);

  estado_t          state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] end_q, end_d;
  logic [W-1:0]     dados_q, dados_d;
  logic             valido_q, valido_d;
  logic [N-1:0]     ack_q, ack_d;

  logic [N-1:0]     eligible;
  logic [SEL_W-1:0] winner;
  logic             any;

  // a requester is masked during its own ack cycle
  assign eligible = req & ~ack_q;

  rr_seletor u_sel (
    .eligible (eligible),
    .ptr      (ptr_q),
    .winner   (winner),
    .any      (any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    end_d    = end_q;
    dados_d  = dados_q;
    valido_d = valido_q;
    ack_d    = '0;
    unique case (state_q)
      OCIOSO: begin
        if (any) begin
          end_d    = winner;
          dados_d  = dados_in[slot_lsb(winner, W) +: W];
          valido_d = 1'b1;
          state_d  = SERVINDO;
        end
      end
      SERVINDO: begin
        if (valido_q && pronto_in) begin
          ack_d[end_q] = 1'b1;
          valido_d     = 1'b0;
`ifdef FIXED_PRIORITY_EN
          ptr_d        = '0;
`else
          ptr_d        = end_q + SEL_W'(1);
`endif
          state_d      = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= OCIOSO;
      ptr_q    <= '0;
      end_q    <= '0;
      dados_q  <= '0;
      valido_q <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      end_q    <= end_d;
      dados_q  <= dados_d;
      valido_q <= valido_d;
      ack_q    <= ack_d;
    end
  end

  assign endereco   = end_q;
  assign dados_out  = dados_q;
  assign valido_out = valido_q;
  assign ack        = ack_q;
  assign ocupado    = (state_q == SERVINDO);

endmodule

// File: tb/tb_arbitro_mux8.sv
// Directed self-checking bench for arbitro_mux8 (round-robin build).
module tb_arbitro_mux8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   req;
  logic [8*W-1:0] dados_in;
  logic         pronto_in;
  logic [2:0]   endereco;
  logic [W-1:0] dados_out;
  logic         valido_out;
  logic [7:0]   ack;
  logic         ocupado;

  int tests = 0;
  int fails = 0;

  arbitro_mux8 #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .dados_in   (dados_in),
    .pronto_in  (pronto_in),
    .endereco   (endereco),
    .dados_out  (dados_out),
    .valido_out (valido_out),
    .ack        (ack),
    .ocupado    (ocupado)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [7:0] v);
    dados_in[8*i +: 8] = v;
  endtask

  initial begin
    logic [7:0] one_hot;
    int idx;
    rst       = 1'b1;
    req       = 8'hFF;
    pronto_in = 1'b1;
    for (int i = 0; i < 8; i++) set_slot(i, 8'hC0 | 8'(i));

    // reset held with all requests high
    tick();
    tick();
    chk("rst_end", 64'(endereco), 64'h0);
    chk("rst_dat", 64'(dados_out), 64'h0);
    chk("rst_val", 64'(valido_out), 64'h0);
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_ocu", 64'(ocupado), 64'h0);
    rst = 1'b0;

    // first grant after reset goes to index 0, then fair rotation
    tick();
    chk("g0_end", 64'(endereco), 64'h0);
    chk("g0_dat", 64'(dados_out), 64'hC0);
    chk("g0_val", 64'(valido_out), 64'h1);
    chk("g0_ocu", 64'(ocupado), 64'h1);
    tick();
    chk("g0_ack", 64'(ack), 64'h01);
    chk("g0_vl0", 64'(valido_out), 64'h0);
    for (int i = 1; i <= 8; i++) begin
      idx = i % 8;
      one_hot = 8'h01 << idx;
      tick();
      chk("rr_end", 64'(endereco), 64'(idx));
      chk("rr_dat", 64'(dados_out), 64'(8'hC0 | 8'(idx)));
      chk("rr_nak", 64'(ack), 64'h0);
      tick();
      chk("rr_ack", 64'(ack), 64'(one_hot));
    end
    req = 8'h00;
    tick();
    chk("idle_ack", 64'(ack), 64'h0);
    chk("idle_val", 64'(valido_out), 64'h0);

    // single request on slot 2
    set_slot(2, 8'h04);
    req = 8'b0000_0100;
    tick();
    chk("s2_end", 64'(endereco), 64'h2);
    chk("s2_dat", 64'(dados_out), 64'h04);
    chk("s2_val", 64'(valido_out), 64'h1);
    req = 8'h00;
    tick();
    chk("s2_ack", 64'(ack), 64'h04);
    tick();
    chk("s2_ack1", 64'(ack), 64'h00);

    // backpressure on slot 5, data changes are ignored
    set_slot(5, 8'hA5);
    req = 8'b0010_0000;
    pronto_in = 1'b0;
    tick();
    chk("bp_end", 64'(endereco), 64'h5);
    req = 8'h00;
    set_slot(5, 8'h5A);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", {ack, valido_out, dados_out},
          64'({8'h00, 1'b1, 8'hA5}));
    end
    pronto_in = 1'b1;
    tick();
    chk("bp_ack", 64'(ack), 64'h20);
    tick();
    chk("bp_ack1", 64'(ack), 64'h00);
    chk("bp_val", 64'(valido_out), 64'h0);

    // wrap-around: 6, then 7 before 0
    req = 8'b0100_0000;
    tick();
    chk("w6_end", 64'(endereco), 64'h6);
    req = 8'h00;
    tick();
    chk("w6_ack", 64'(ack), 64'h40);
    req = 8'b1000_0001;
    tick();
    chk("w7_end", 64'(endereco), 64'h7);
    tick();
    chk("w7_ack", 64'(ack), 64'h80);
    tick();
    chk("w0_end", 64'(endereco), 64'h0);
    req = 8'h00;
    tick();
    chk("w0_ack", 64'(ack), 64'h01);

    // reset in the middle of a SERVINDO grant to index 3
    req = 8'b0000_1000;
    pronto_in = 1'b0;
    tick();
    chk("r3_end", 64'(endereco), 64'h3);
    chk("r3_ocu", 64'(ocupado), 64'h1);
    req = 8'h00;
    #2;
    rst = 1'b1;
    #1;
    chk("r3_val", 64'(valido_out), 64'h0);
    chk("r3_ocu0", 64'(ocupado), 64'h0);
    chk("r3_end0", 64'(endereco), 64'h0);
    tick();
    chk("r3_ack", 64'(ack), 64'h0);
    rst = 1'b0;
    pronto_in = 1'b1;
    req = 8'hFF;
    tick();
    chk("r3_ptr", 64'(endereco), 64'h0);
    tick();
    chk("r3_ack0", 64'(ack), 64'h01);
    req = 8'h00;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
